shift_4_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the 4-bit universal shift register `shift_4` and drives its `sel`, `din`, `dinr` and `dinl` inputs. It accepts one command at a time over a valid/ready handshake: load a word, clear, or shift left/right N positions with a chosen fill bit. It expands each command into the exact per-cycle control sequence `shift_4` needs, then pulses `done`. All outputs are registered, so they can feed `shift_4` directly on the same clock.

---
 rtl/shift_4_ctrl.sv | 179 +++++++++++++++++
 tb/tb_shift_4_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_4_ctrl.sv
// shift_4_ctrl
// Command sequencer for the 4-bit universal shift register shift_4. Takes one
// command at a time over valid/ready (load, clear, shift right/left N places
// with a fill bit), expands it into the per-cycle sel/din/dinr/dinl sequence
// shift_4 needs, then pulses done for one cycle.
//
// Ports:
//   clk        rising-edge clock shared with shift_4
//   rst_n      synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  controller can accept (IDLE and not in reset), combinational
//   cmd_op     00 load, 01 shift right, 10 shift left, 11 clear
//   cmd_data   load value (op 00)
//   cmd_cnt    shift count (ops 01/10)
//   cmd_fill   serial fill bit (ops 01/10)
//   sel        to shift_4: 00 hold, 01 right, 10 left, 11 parallel load
//   din        parallel data to shift_4
//   dinr       serial input for right shift
//   dinl       serial input for left shift
//   busy       controller is not IDLE
//   done       one-cycle completion pulse
module shift_4_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    output logic [1:0]       sel,
    output logic [3:0]       din,
    output logic             dinr,
    output logic             dinl,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_RIGHT = 2'b01;
    localparam logic [1:0] OP_LEFT  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Captured command payload; only meaningful while busy, so not reset.
    logic [1:0]       op_q, op_nxt;
    logic [3:0]       data_q, data_nxt;
    logic             fill_q, fill_nxt;

    // Next values of the registered outputs.
    logic [1:0]       sel_nxt;
    logic [3:0]       din_nxt;
    logic             dinr_nxt, dinl_nxt, done_nxt;

    assign cmd_ready = (state == IDLE) && rst_n;
    assign busy      = (state != IDLE);

    // Next-state logic. Outputs are derived from the *next* state so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        data_nxt  = data_q;
        fill_nxt  = fill_q;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_nxt   = cmd_op;
                    data_nxt = cmd_data;
                    fill_nxt = cmd_fill;
                    if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
                        state_nxt = LOAD;
                    end else if (cmd_cnt != '0) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = cmd_cnt;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            LOAD: begin
                state_nxt = DONE;
            end
            SHIFT: begin
                // The cycle with cnt==1 is the final shift.
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        sel_nxt  = SEL_HOLD;
        din_nxt  = 4'b0000;
        dinr_nxt = 1'b0;
        dinl_nxt = 1'b0;
        done_nxt = 1'b0;

        case (state_nxt)
            LOAD: begin
                sel_nxt = SEL_LOAD;
                // Clear is a parallel load of zero; its data is ignored.
                din_nxt = (op_nxt == OP_LOAD) ? data_nxt : 4'b0000;
            end
            SHIFT: begin
                if (op_nxt == OP_RIGHT) begin
                    sel_nxt  = SEL_RIGHT;
                    dinr_nxt = fill_nxt;
                end else if (op_nxt == OP_LEFT) begin
                    sel_nxt  = SEL_LEFT;
                    dinl_nxt = fill_nxt;
                end
            end
            DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                sel_nxt = SEL_HOLD;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= SEL_HOLD;
            din   <= 4'b0000;
            dinr  <= 1'b0;
            dinl  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            din   <= din_nxt;
            dinr  <= dinr_nxt;
            dinl  <= dinl_nxt;
            done  <= done_nxt;
        end
    end

    // Payload capture
    always_ff @(posedge clk) begin
        op_q   <= op_nxt;
        data_q <= data_nxt;
        fill_q <= fill_nxt;
    end

endmodule

// File: tb/tb_shift_4_ctrl.sv
module tb_shift_4_ctrl;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [3:0]       cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_fill;
    logic [1:0]       sel;
    logic [3:0]       din;
    logic             dinr;
    logic             dinl;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fails;

    // Behavioural shift_4 driven by the controller outputs.
    logic [3:0] sr;

    shift_4_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .cmd_fill  (cmd_fill),
        .sel       (sel),
        .din       (din),
        .dinr      (dinr),
        .dinl      (dinl),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial sr = 4'b0000;
    always @(posedge clk) begin
        case (sel)
            2'b01:   sr <= {dinr, sr[3:1]};
            2'b10:   sr <= {sr[2:0], dinl};
            2'b11:   sr <= din;
            default: sr <= sr;
        endcase
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: rising edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle outputs (sel/din/dinr/dinl/done all zero) plus busy/ready.
    task automatic chk_quiet(input string tag, input logic exp_busy, input logic exp_ready);
        chk_eq({tag, ".sel"},   32'(sel),       32'd0);
        chk_eq({tag, ".din"},   32'(din),       32'd0);
        chk_eq({tag, ".dinr"},  32'(dinr),      32'd0);
        chk_eq({tag, ".dinl"},  32'(dinl),      32'd0);
        chk_eq({tag, ".done"},  32'(done),      32'd0);
        chk_eq({tag, ".busy"},  32'(busy),      32'(exp_busy));
        chk_eq({tag, ".ready"}, 32'(cmd_ready), 32'(exp_ready));
    endtask

    task automatic chk_done(input string tag);
        chk_eq({tag, ".sel"},   32'(sel),       32'd0);
        chk_eq({tag, ".din"},   32'(din),       32'd0);
        chk_eq({tag, ".done"},  32'(done),      32'd1);
        chk_eq({tag, ".busy"},  32'(busy),      32'd1);
        chk_eq({tag, ".ready"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic chk_ctl(input string tag, input logic [1:0] e_sel, input logic [3:0] e_din,
                           input logic e_dinr, input logic e_dinl);
        chk_eq({tag, ".sel"},   32'(sel),       32'(e_sel));
        chk_eq({tag, ".din"},   32'(din),       32'(e_din));
        chk_eq({tag, ".dinr"},  32'(dinr),      32'(e_dinr));
        chk_eq({tag, ".dinl"},  32'(dinl),      32'(e_dinl));
        chk_eq({tag, ".done"},  32'(done),      32'd0);
        chk_eq({tag, ".busy"},  32'(busy),      32'd1);
        chk_eq({tag, ".ready"}, 32'(cmd_ready), 32'd0);
    endtask

    // Present a command and take the accept edge; valid is dropped afterwards.
    task automatic issue(input logic [1:0] op, input logic [3:0] data,
                         input logic [CNT_W-1:0] cnt, input logic fill, input string tag);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
        chk_eq({tag, ".ready_pre"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 4'b1111;
        cmd_cnt   = '0;
        cmd_fill  = 1'b0;

        // Reset held for two edges with a command offered.
        @(negedge clk);
        chk_eq("rst0.ready", 32'(cmd_ready), 32'd0);
        tick();
        chk_quiet("rst1", 1'b0, 1'b0);
        tick();
        chk_quiet("rst2", 1'b0, 1'b0);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk_eq("rst_rel.ready", 32'(cmd_ready), 32'd1);
        chk_eq("rst_rel.busy",  32'(busy),      32'd0);

        // Load 1000.
        issue(2'b00, 4'b1000, '0, 1'b0, "ld");
        chk_ctl("ld.k1", 2'b11, 4'b1000, 1'b0, 1'b0);
        tick();
        chk_done("ld.k2");
        chk_eq("ld.sr", 32'(sr), 32'h8);
        tick();
        chk_quiet("ld.k3", 1'b0, 1'b1);

        // Shift right 2 with fill 1: 1000 -> 1100 -> 1110.
        issue(2'b01, 4'b0000, 3'd2, 1'b1, "sr2");
        chk_ctl("sr2.k1", 2'b01, 4'b0000, 1'b1, 1'b0);
        tick();
        chk_ctl("sr2.k2", 2'b01, 4'b0000, 1'b1, 1'b0);
        tick();
        chk_done("sr2.k3");
        chk_eq("sr2.sr", 32'(sr), 32'hE);
        tick();
        chk_quiet("sr2.k4", 1'b0, 1'b1);

        // Shift left 3 with fill 1: 1110 -> 1101 -> 1011 -> 0111.
        issue(2'b10, 4'b0000, 3'd3, 1'b1, "sl3");
        for (int i = 1; i <= 3; i++) begin
            chk_ctl($sformatf("sl3.k%0d", i), 2'b10, 4'b0000, 1'b0, 1'b1);
            tick();
        end
        chk_done("sl3.k4");
        chk_eq("sl3.sr", 32'(sr), 32'h7);
        tick();
        chk_quiet("sl3.k5", 1'b0, 1'b1);

        // Zero-count shift: straight to DONE, sel stays 00.
        issue(2'b01, 4'b0000, 3'd0, 1'b1, "z0");
        chk_done("z0.k1");
        chk_eq("z0.dinr", 32'(dinr), 32'd0);
        tick();
        chk_quiet("z0.k2", 1'b0, 1'b1);
        chk_eq("z0.sr", 32'(sr), 32'h7);

        // Clear ignores cmd_data.
        issue(2'b11, 4'b1111, '0, 1'b0, "clr");
        chk_ctl("clr.k1", 2'b11, 4'b0000, 1'b0, 1'b0);
        tick();
        chk_done("clr.k2");
        chk_eq("clr.sr", 32'(sr), 32'h0);
        tick();
        chk_quiet("clr.k3", 1'b0, 1'b1);

        // Back-to-back with valid held and payload changed while busy.
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 4'b0101;
        chk_eq("b2b.ready_pre", 32'(cmd_ready), 32'd1);
        tick();
        cmd_data = 4'b1010;
        cmd_op   = 2'b00;
        chk_ctl("b2b.k1", 2'b11, 4'b0101, 1'b0, 1'b0);
        tick();
        chk_done("b2b.k2");
        chk_eq("b2b.sr", 32'(sr), 32'h5);
        tick();
        chk_quiet("b2b.k3", 1'b0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk_ctl("b2b.k4", 2'b11, 4'b1010, 1'b0, 1'b0);
        tick();
        chk_done("b2b.k5");
        chk_eq("b2b.sr2", 32'(sr), 32'hA);
        tick();
        chk_quiet("b2b.k6", 1'b0, 1'b1);

        // Reset during the 3rd cycle of a 7-cycle left shift.
        issue(2'b10, 4'b0000, 3'd7, 1'b0, "mid");
        chk_ctl("mid.k1", 2'b10, 4'b0000, 1'b0, 1'b0);
        tick();
        chk_ctl("mid.k2", 2'b10, 4'b0000, 1'b0, 1'b0);
        tick();
        chk_ctl("mid.k3", 2'b10, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_quiet("mid.k4", 1'b0, 1'b0);
        tick();
        chk_quiet("mid.k5", 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_eq("mid.rel.ready", 32'(cmd_ready), 32'd1);
        issue(2'b00, 4'b0011, '0, 1'b0, "post");
        chk_ctl("post.k1", 2'b11, 4'b0011, 1'b0, 1'b0);
        tick();
        chk_done("post.k2");
        chk_eq("post.sr", 32'(sr), 32'h3);
        tick();
        chk_quiet("post.k3", 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
